// File: rtl/mux8_rr_arbiter.sv
// Gathers words from 8 source channels onto one stream tagged with the source index.
// Latency: a word granted in cycle n is visible on out_data/out_sel in cycle n+1.
// Backpressure: while out_valid=1 and out_ready=0, outputs and pointer freeze and no channel is granted.
module mux8_rr_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] ptr;
  logic [2:0] idx;
  logic [2:0] gnt_idx;
  logic       found;
  logic       can_load;
  logic       grant;

  assign out_valid = (state == FULL);
  assign can_load  = !out_valid | out_ready;

  // Round-robin scan of requests starting at ptr, wrapping 7->0; first hit wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = 3'd0;
    idx     = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && in_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    // Nothing is consumed while reset is held, so no grant is advertised either.
    grant    = can_load & found & !reset;
    in_ready = grant ? (8'b1 << gnt_idx) : 8'b0;
  end

  // Output register occupancy: a grant always fills it, a drain without grant empties it.
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: if (grant) state_nx = FULL;
      FULL: begin
        if (grant)          state_nx = FULL;
        else if (out_ready) state_nx = EMPTY;
      end
      default: state_nx = EMPTY;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clock) begin
    if (reset) state <= EMPTY;
    else       state <= state_nx;
  end

  // Capture the granted word and its index; the pointer moves only on a grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_data <= '0;
      out_sel  <= 3'd0;
      ptr      <= 3'd0;
    end else if (grant) begin
      out_data <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_sel  <= gnt_idx;
      ptr      <= gnt_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios plus random traffic.
// Latency: reference model updates on each rising edge; outputs compared on falling edges.
// Backpressure: random out_ready exercises stall, drain and simultaneous drain/load.
module tb_mux8_rr_arbiter;

  localparam int W = 16;

  logic           clock = 1'b0;
  logic           reset;
  logic [7:0]     in_valid;
  logic [8*W-1:0] in_data;
  logic [7:0]     in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;

  logic [W-1:0]   d [8];

  int checks   = 0;
  int failures = 0;

  // Reference model state (spec-level view of the block).
  bit   armed = 0;
  bit   m_valid;
  int   m_data;
  int   m_sel;
  int   m_ptr;

  mux8_rr_arbiter #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clock = ~clock;

  // Pack per-channel words onto the flat input bus.
  always_comb begin
    in_data = '0;
    for (int i = 0; i < 8; i++) in_data[i*W +: W] = d[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requesting channel in cyclic order from p, or -1 when nobody requests.
  function automatic int first_req(input int p, input logic [7:0] v);
    for (int k = 0; k < 8; k++)
      if (v[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  function automatic logic [7:0] exp_ready();
    int g;
    if (reset) return 8'h00;
    if (m_valid && !out_ready) return 8'h00;
    g = first_req(m_ptr, in_valid);
    if (g < 0) return 8'h00;
    return 8'(1 << g);
  endfunction

  // Reference model: what the output register and pointer hold after each edge.
  always @(posedge clock) begin
    int g;
    if (reset) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
      armed   = 1;
    end else if (armed) begin
      g = first_req(m_ptr, in_valid);
      if ((!m_valid || out_ready) && g >= 0) begin
        m_data  = int'(d[g]);
        m_sel   = g;
        m_valid = 1;
        m_ptr   = (g + 1) % 8;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  // Compare DUT against the model on every falling edge once reset has been seen.
  always @(negedge clock) begin
    if (armed) begin
      chk("cmp_in_ready",  32'(in_ready),  32'(exp_ready()));
      chk("cmp_out_valid", 32'(out_valid), 32'(m_valid));
      chk("cmp_out_data",  32'(out_data),  32'(m_data));
      chk("cmp_out_sel",   32'(out_sel),   32'(m_sel));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) d[i] = 16'(16'h100 + i);

    // Reset held two cycles with everyone requesting.
    step(); #1;
    chk("rst_out_valid_c1", 32'(out_valid), 32'd0);
    chk("rst_in_ready_c1",  32'(in_ready),  32'd0);
    step(); #1;
    chk("rst_out_valid_c2", 32'(out_valid), 32'd0);
    chk("rst_in_ready_c2",  32'(in_ready),  32'd0);
    reset = 1'b0; #1;
    chk("post_rst_grant0", 32'(in_ready), 32'h01);
    step();
    chk("post_rst_sel0",   32'(out_sel),   32'd0);
    chk("post_rst_valid",  32'(out_valid), 32'd1);

    // Single channel 5.
    in_valid = 8'h20; d[5] = 16'hBEEF; #1;
    chk("single_in_ready", 32'(in_ready), 32'h20);
    step();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data",  32'(out_data),  32'hBEEF);
    chk("single_sel",   32'(out_sel),   32'd5);
    chk("single_ptr6",  32'(m_ptr),     32'd6);

    // Grant channel 7 so the pointer wraps to 0, then all channels for 10 cycles.
    in_valid = 8'h80;
    step();
    d[5] = 16'h105;
    in_valid = 8'hFF;
    for (int n = 0; n < 10; n++) begin
      step();
      chk("rr_sel",   32'(out_sel),   32'(n % 8));
      chk("rr_data",  32'(out_data),  32'(16'h100 + (n % 8)));
      chk("rr_valid", 32'(out_valid), 32'd1);
    end

    // Advance to out_sel=3, then stall with channels 4 and 6 requesting.
    step();
    step();
    in_valid = 8'h50; out_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready),  32'd0);
      chk("stall_sel",      32'(out_sel),   32'd3);
      chk("stall_data",     32'(out_data),  32'h103);
      chk("stall_valid",    32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b1; #1;
    chk("unstall_grant4", 32'(in_ready), 32'h10);
    step();
    chk("unstall_sel4", 32'(out_sel), 32'd4);

    // Drain to empty, then a lone request from channel 2 with ptr=5.
    in_valid = 8'h00;
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_sel",   32'(out_sel),   32'd4);
    step();
    chk("drain_ptr5",  32'(m_ptr),     32'd5);
    in_valid = 8'h04; d[2] = 16'hCAFE; #1;
    chk("wrap_grant2", 32'(in_ready), 32'h04);
    step();
    chk("wrap_sel2",  32'(out_sel),  32'd2);
    chk("wrap_data",  32'(out_data), 32'hCAFE);

    // Reach ptr=6 via channel 5, stall, then reset mid-stream.
    in_valid = 8'h20;
    step();
    in_valid = 8'h82; out_ready = 1'b0;
    step();
    chk("pre_rst_ptr6", 32'(m_ptr), 32'd6);
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ptr0",  32'(m_ptr),     32'd0);
    reset = 1'b0; out_ready = 1'b1; #1;
    chk("mid_rst_grant1", 32'(in_ready), 32'h02);
    step();
    chk("mid_rst_sel1", 32'(out_sel), 32'd1);
    step();
    chk("mid_rst_sel7", 32'(out_sel), 32'd7);

    // Random traffic checked by the compare process.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clock); #1;
      in_valid  = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 8; i++) d[i] = 16'($urandom);
    end
    reset = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Sequential counterpart of the 8-way demultiplexer. It gathers words from 8 source channels onto one output stream.
- Each output word is tagged with its 3-bit channel index (out_sel), so the pair (out_data, out_sel) can drive a DMux8Way-style router directly.
- A round-robin arbiter picks among requesting channels. A one-entry output register provides a valid/ready handshake toward the consumer.

Parameters:
- WIDTH, 16, data width of each channel word and of out_data.

Ports:
- clock  input  1  single system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  8  bit i high: channel i offers a word.
- in_data  input  8*WIDTH  channel i word at bits [i*WIDTH +: WIDTH].
- in_ready  output  8  one-hot (or zero) grant; channel i word is consumed on a cycle where in_valid[i] and in_ready[i] are both high.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word when out_valid is also high.
- out_data  output  WIDTH  registered word.
- out_sel  output  3  index of the channel that supplied out_data.

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0.
  - Reset overrides any handshake in the same cycle; a word held in the output register is discarded.
- States:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - Combinational signal `can_load = !out_valid | out_ready`.
- Arbitration (combinational):
  - If can_load, the arbiter scans in_valid starting at index ptr, ascending, wrapping 7->0.
  - The first set bit g is granted: in_ready = 1<<g. Otherwise in_ready = 0.
  - in_ready never has more than one bit set.
  - in_ready may depend on in_valid and out_ready in the same cycle (no registered ready).
- Grant cycle, on the clock edge:
  - out_data <= in_data[g]; out_sel <= g; out_valid <= 1; ptr <= (g+1) mod 8.
- Drain without grant:
  - If out_valid and out_ready are high and no channel requests: out_valid <= 0.
  - out_data and out_sel keep their last values.
- Simultaneous drain and load: allowed. Throughput is one word per cycle when the consumer keeps out_ready=1.
- Stall (out_valid=1, out_ready=0):
  - out_data, out_sel, out_valid and ptr are frozen; in_ready = 0.
- ptr update rule: ptr advances only on a grant, never on idle cycles. Fairness: with all 8 channels requesting continuously, grants go 0,1,...,7,0,... and each channel waits at most 7 grants.
- Latency: a word granted on cycle n appears on out_data/out_sel after the edge ending cycle n, i.e. visible in cycle n+1.
- Source rules:
  - A source may deassert in_valid at any time before it is granted; no state is kept per channel.
  - in_data must be stable while in_valid is high and ungranted.
- Arithmetic: ptr is 3 bits and wraps naturally. Index math is modulo 8 with no overflow handling needed.

Test Plan:
- Reset: assert reset for 2 cycles with all in_valid=8'hFF and out_ready=1.
  - Required: out_valid=0, in_ready=0 during reset.
  - Required: first grant after release is channel 0 (out_sel=0 one cycle later).
- Single channel: in_valid=8'b0010_0000, in_data[5]=16'hBEEF, out_ready=1.
  - Required: in_ready=8'b0010_0000 in that cycle.
  - Required: next cycle out_valid=1, out_data=16'hBEEF, out_sel=5.
  - Required: next grant search begins at ptr=6.
- Round-robin wrap: all channels valid with in_data[i]=i+16'h100, out_ready=1 for 10 cycles.
  - Required: out_sel sequence 0,1,2,3,4,5,6,7,0,1.
  - Required: out_data matches 16'h100+out_sel; out_valid stays 1 continuously.
- Backpressure: FULL with out_sel=3, out_data=16'h0103; hold out_ready=0 for 4 cycles with channels 4 and 6 valid.
  - Required: outputs frozen and in_ready=0 throughout the stall.
  - Required: on out_ready=1, channel 4 is granted in that same cycle and out_sel=4 the next cycle.
- Drain to empty: FULL, in_valid=0, out_ready=1.
  - Required: next cycle out_valid=0 and out_sel unchanged.
  - Required: a later request from channel 2 with ptr=5 is granted (wrap search 5,6,7,0,1,2).
- Reset mid-stream: assert reset while FULL, stalled, with ptr=6.
  - Required: after the edge out_valid=0 and ptr=0.
  - Required: with channels 1 and 7 then valid, channel 1 is granted first.
